// File: rtl/fc_tiled.sv
// fc_tiled: time-multiplexed fully-connected layer with NUM_PE signed MAC lanes.
// Output neurons are swept in passes of NUM_PE, one input element per cycle.
// Optional feature macro: FC_RELU_EN (clamps negative results to zero on write-back).
module fc_tiled #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned ACC_WIDTH   = 32,
   parameter int unsigned NUM_INPUTS  = 48,
   parameter int unsigned NUM_OUTPUTS = 10,
   parameter int unsigned NUM_PE      = 4,
   parameter int unsigned BIAS_SHIFT  = 2
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic                                      start,
   input  logic [NUM_INPUTS*DATA_WIDTH-1:0]          in_vec_flat,
   input  logic [NUM_OUTPUTS*NUM_INPUTS*DATA_WIDTH-1:0] w_mat_flat,
   input  logic [NUM_OUTPUTS*DATA_WIDTH-1:0]         bias_flat,
   output logic                                      busy,
   output logic                                      done,
   output logic [NUM_OUTPUTS*ACC_WIDTH-1:0]          out_vec_flat
);

   localparam int unsigned DW  = DATA_WIDTH;
   localparam int unsigned AW  = ACC_WIDTH;
   localparam int unsigned N   = NUM_INPUTS;
   localparam int unsigned O   = NUM_OUTPUTS;
   localparam int unsigned NP  = (O + NUM_PE - 1) / NUM_PE;
   localparam int unsigned IW  = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned PW  = (NP > 1) ? $clog2(NP) : 1;
   localparam int unsigned OW  = (O > 1) ? $clog2(O) : 1;
   localparam int unsigned WBW = $clog2(O * N * DW);
   // sum width wide enough for accumulator plus shifted bias without overflow
   localparam int unsigned SW  = AW + DW + BIAS_SHIFT + 1;

   localparam logic signed [SW-1:0] MAXV = {{(SW-AW+1){1'b0}}, {(AW-1){1'b1}}};
   localparam logic signed [SW-1:0] MINV = {{(SW-AW+1){1'b1}}, {(AW-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB, S_DONE} state_t;

   state_t                 state;
   logic [IW-1:0]          idx;
   logic [PW-1:0]          pass;
   logic signed [DW-1:0]   in_r   [N];
   logic signed [DW-1:0]   bias_r [O];
   logic signed [AW-1:0]   acc    [NUM_PE];
   logic signed [AW-1:0]   out_r  [O];

   int unsigned            lane_o   [NUM_PE];
   int unsigned            lane_s   [NUM_PE];
   logic                   lane_act [NUM_PE];
   logic signed [DW-1:0]   lane_w   [NUM_PE];
   logic signed [2*DW-1:0] prod     [NUM_PE];
   logic signed [SW-1:0]   sum      [NUM_PE];
   logic signed [AW-1:0]   wb_val   [NUM_PE];

   // per-lane neuron select, product and saturated write-back value
   always_comb begin
      for (int l = 0; l < int'(NUM_PE); l++) begin
         lane_o[l]   = 32'(pass) * NUM_PE + 32'(l);
         lane_act[l] = (lane_o[l] < O);
         lane_s[l]   = lane_act[l] ? lane_o[l] : 32'd0;
         lane_w[l]   = $signed(w_mat_flat[WBW'((lane_s[l] * N + 32'(idx)) * DW) +: DW]);
         prod[l]     = in_r[idx] * lane_w[l];
         sum[l]      = SW'(acc[l]) + (SW'(bias_r[OW'(lane_s[l])]) <<< BIAS_SHIFT);
         if (sum[l] > MAXV) begin
            wb_val[l] = AW'(MAXV);
         end else if (sum[l] < MINV) begin
            wb_val[l] = AW'(MINV);
         end else begin
            wb_val[l] = AW'(sum[l]);
         end
`ifdef FC_RELU_EN
         if (wb_val[l][AW-1]) begin
            wb_val[l] = '0;
         end
`endif
      end
   end

   // control FSM, capture registers, accumulators and result slots
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         idx   <= '0;
         pass  <= '0;
         for (int i = 0; i < int'(N); i++) in_r[i] <= '0;
         for (int o = 0; o < int'(O); o++) begin
            bias_r[o] <= '0;
            out_r[o]  <= '0;
         end
         for (int l = 0; l < int'(NUM_PE); l++) acc[l] <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               // the done cycle is spent in IDLE; a start there is not taken
               if (start && !done) begin
                  for (int i = 0; i < int'(N); i++) in_r[i] <= $signed(in_vec_flat[i*DW +: DW]);
                  for (int o = 0; o < int'(O); o++) bias_r[o] <= $signed(bias_flat[o*DW +: DW]);
                  for (int l = 0; l < int'(NUM_PE); l++) acc[l] <= '0;
                  idx   <= '0;
                  pass  <= '0;
                  busy  <= 1'b1;
                  state <= S_MAC;
               end
            end
            S_MAC: begin
               for (int l = 0; l < int'(NUM_PE); l++) begin
                  if (lane_act[l]) acc[l] <= acc[l] + AW'(prod[l]);
               end
               if (idx == IW'(N - 1)) begin
                  state <= S_WB;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            S_WB: begin
               for (int l = 0; l < int'(NUM_PE); l++) begin
                  if (lane_act[l]) out_r[OW'(lane_s[l])] <= wb_val[l];
               end
               if (pass == PW'(NP - 1)) begin
                  state <= S_DONE;
               end else begin
                  pass  <= pass + 1'b1;
                  idx   <= '0;
                  for (int l = 0; l < int'(NUM_PE); l++) acc[l] <= '0;
                  state <= S_MAC;
               end
            end
            S_DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // flatten result slots onto the output bus
   always_comb begin
      for (int o = 0; o < int'(O); o++) out_vec_flat[o*AW +: AW] = out_r[o];
   end

endmodule

// File: tb/tb_fc_tiled.sv
// tb_fc_tiled: scoreboard bench for fc_tiled (main config plus a narrow saturation config).
module tb_fc_tiled;

   localparam int unsigned DW  = 8;
   localparam int unsigned AW  = 32;
   localparam int unsigned N   = 4;
   localparam int unsigned O   = 3;
   localparam int unsigned PE  = 2;
   localparam int unsigned BS  = 2;
   localparam int LAT  = int'(((O + PE - 1) / PE) * (N + 1) + 1);

   localparam int unsigned SAW = 16;
   localparam int unsigned SN  = 2;
   localparam int unsigned SBS = 3;
   localparam int SLAT = int'(1 * (SN + 1) + 1);

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic                  start;
   logic [N*DW-1:0]       in_flat;
   logic [O*N*DW-1:0]     w_flat;
   logic [O*DW-1:0]       b_flat;
   logic                  busy, done;
   logic [O*AW-1:0]       out_flat;

   logic                  s_start;
   logic [SN*DW-1:0]      s_in;
   logic [SN*DW-1:0]      s_w;
   logic [DW-1:0]         s_b;
   logic                  s_busy, s_done;
   logic [SAW-1:0]        s_out;

   int total = 0;
   int bad   = 0;
   int n_done = 0, n_ops = 0, s_ndone = 0, s_nops = 0;

   int in_m [N];
   int w_m  [O][N];
   int b_m  [O];
   int sin_m [SN];
   int sw_m  [SN];
   int sb_m;

   longint exp_q [$];
   longint s_q   [$];

   fc_tiled #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .NUM_INPUTS(N), .NUM_OUTPUTS(O),
              .NUM_PE(PE), .BIAS_SHIFT(BS)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_vec_flat(in_flat),
      .w_mat_flat(w_flat), .bias_flat(b_flat), .busy(busy), .done(done),
      .out_vec_flat(out_flat));

   fc_tiled #(.DATA_WIDTH(DW), .ACC_WIDTH(SAW), .NUM_INPUTS(SN), .NUM_OUTPUTS(1),
              .NUM_PE(1), .BIAS_SHIFT(SBS)) u_sat (
      .clk(clk), .rst_n(rst_n), .start(s_start), .in_vec_flat(s_in),
      .w_mat_flat(s_w), .bias_flat(s_b), .busy(s_busy), .done(s_done),
      .out_vec_flat(s_out));

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic signed [63:0] got,
                        input logic signed [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
      end
   endtask

   // reference: wrap accumulator to aw bits, add shifted bias, saturate, optional relu
   function automatic longint model_fc(input longint raw, input longint bias,
                                       input int aw, input int bs);
      longint a, s, maxv, minv;
      a    = (raw <<< (64 - aw)) >>> (64 - aw);
      s    = a + (bias <<< bs);
      maxv = (64'sd1 <<< (aw - 1)) - 1;
      minv = -(64'sd1 <<< (aw - 1));
      if (s > maxv) s = maxv;
      if (s < minv) s = minv;
`ifdef FC_RELU_EN
      if (s < 0) s = 0;
`endif
      return s;
   endfunction

   task automatic load_dut();
      for (int i = 0; i < int'(N); i++) in_flat[i*DW +: DW] = DW'(in_m[i]);
      for (int o = 0; o < int'(O); o++) begin
         b_flat[o*DW +: DW] = DW'(b_m[o]);
         for (int i = 0; i < int'(N); i++) w_flat[(o*N+i)*DW +: DW] = DW'(w_m[o][i]);
      end
   endtask

   task automatic push_dut();
      for (int o = 0; o < int'(O); o++) begin
         longint s = 0;
         for (int i = 0; i < int'(N); i++) s += longint'(in_m[i]) * longint'(w_m[o][i]);
         exp_q.push_back(model_fc(s, longint'(b_m[o]), int'(AW), int'(BS)));
      end
      n_ops++;
   endtask

   task automatic rand_dut();
      for (int i = 0; i < int'(N); i++) in_m[i] = int'($urandom_range(0, 255)) - 128;
      for (int o = 0; o < int'(O); o++) begin
         b_m[o] = int'($urandom_range(0, 255)) - 128;
         for (int i = 0; i < int'(N); i++) w_m[o][i] = int'($urandom_range(0, 255)) - 128;
      end
   endtask

   task automatic basic_dut();
      for (int i = 0; i < int'(N); i++) begin
         in_m[i]    = i + 1;
         w_m[0][i]  = 1;
         w_m[1][i]  = -1;
         w_m[2][i]  = (i == 0) ? 2 : 0;
      end
      b_m[0] = 1; b_m[1] = 0; b_m[2] = -1;
   endtask

   // scoreboard pop on each main-DUT done pulse
   always @(negedge clk) begin
      if (rst_n && done) begin
         n_done++;
         check("busy_in_done", busy, 0);
         if (exp_q.size() < int'(O)) begin
            check("sb_depth", exp_q.size(), O);
         end else begin
            for (int o = 0; o < int'(O); o++)
               check($sformatf("out%0d", o), $signed(out_flat[o*AW +: AW]), exp_q.pop_front());
         end
      end
   end

   // scoreboard pop on each saturation-DUT done pulse
   always @(negedge clk) begin
      if (rst_n && s_done) begin
         s_ndone++;
         if (s_q.size() == 0) check("s_sb_depth", s_q.size(), 1);
         else check("sat_out", $signed(s_out), s_q.pop_front());
      end
   end

   // one request on the main DUT; hs adds stray start pulses mid-MAC and in the done cycle
   task automatic run_dut(input bit hs);
      int lat;
      load_dut();
      @(negedge clk);
      start = 1'b1;
      push_dut();
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      check("busy_after_accept", busy, 1);
      while (!done && lat < 200) begin
         start = (hs && lat == 3) ? 1'b1 : 1'b0;
         @(negedge clk);
         lat++;
      end
      check("latency", lat, LAT);
      start = hs;
      @(negedge clk);
      start = 1'b0;
      check("done_one_cycle", done, 0);
      if (hs) check("done_cycle_start_ignored", busy, 0);
   endtask

   task automatic run_sat();
      int lat;
      for (int i = 0; i < int'(SN); i++) begin
         s_in[i*DW +: DW] = DW'(sin_m[i]);
         s_w[i*DW +: DW]  = DW'(sw_m[i]);
      end
      s_b = DW'(sb_m);
      @(negedge clk);
      s_start = 1'b1;
      begin
         longint s = 0;
         for (int i = 0; i < int'(SN); i++) s += longint'(sin_m[i]) * longint'(sw_m[i]);
         s_q.push_back(model_fc(s, longint'(sb_m), int'(SAW), int'(SBS)));
         s_nops++;
      end
      @(negedge clk);
      s_start = 1'b0;
      lat = 0;
      while (!s_done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check("sat_latency", lat, SLAT);
      @(negedge clk);
   endtask

   initial begin
      start = 1'b0; in_flat = '0; w_flat = '0; b_flat = '0;
      s_start = 1'b0; s_in = '0; s_w = '0; s_b = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      for (int o = 0; o < int'(O); o++) check("rst_out", $signed(out_flat[o*AW +: AW]), 0);
      rst_n = 1'b1;

      // random runs; the last one leaves a prior value in slot 2
      for (int k = 0; k < 3; k++) begin
         rand_dut();
         run_dut(1'b0);
      end

      // basic vector, also overwrites slot 2 through the masked pass
      basic_dut();
      run_dut(1'b0);
`ifdef FC_RELU_EN
      check("basic_out2_const", $signed(out_flat[2*AW +: AW]), 0);
`else
      check("basic_out2_const", $signed(out_flat[2*AW +: AW]), -2);
`endif

      // handshake: stray starts ignored, then accepted two cycles after done
      rand_dut();
      run_dut(1'b1);
      basic_dut();
      run_dut(1'b0);

      // reset during pass 1
      rand_dut();
      load_dut();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (7) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      for (int o = 0; o < int'(O); o++) check("midrst_out", $signed(out_flat[o*AW +: AW]), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst_no_done", n_done, n_ops);
      basic_dut();
      run_dut(1'b0);

      // saturation, positive then negative
      sin_m[0] = 127; sin_m[1] = 127; sw_m[0] = 127; sw_m[1] = 127; sb_m = 127;
      run_sat();
`ifndef FC_RELU_EN
      check("sat_pos_const", $signed(s_out), 32767);
`endif
      sin_m[0] = -128; sin_m[1] = -128; sb_m = -128;
      run_sat();
`ifndef FC_RELU_EN
      check("sat_neg_const", $signed(s_out), -32768);
`endif

      repeat (4) @(negedge clk);
      check("done_count", n_done, n_ops);
      check("sat_done_count", s_ndone, s_nops);
      check("sb_left", exp_q.size(), 0);
      check("s_sb_left", s_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
